// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: round-robin arbiter sharing one byte-wide transmit stream between four UDP
// frame sources. It grants one source at a time and forwards its frame with one register
// stage. It also enforces an inter-frame gap, a start timeout and a maximum frame length.
//
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   req[3:0]       - per-source frame request
//   ch_data[31:0]  - source bytes, source i on [8i+7:8i]
//   ch_valid[3:0]  - per-source byte valid (whole frame, no holes)
//   grant[3:0]     - registered one-hot grant
//   tx_data[7:0]   - forwarded byte
//   tx_data_valid  - forwarded byte valid
//   busy           - arbiter not idle
//   frames_sent    - completed frame count (wraps)
//   timeout_pulse  - start timeout or request withdrawal
//   trunc_pulse    - frame cut at MAX_LEN
module udp_tx_arbiter #(
  parameter int unsigned IFG      = 12,
  parameter int unsigned START_TO = 64,
  parameter int unsigned MAX_LEN  = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] ch_data,
  input  logic [3:0]  ch_valid,
  output logic [3:0]  grant,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  output logic        busy,
  output logic [15:0] frames_sent,
  output logic        timeout_pulse,
  output logic        trunc_pulse
);

  localparam logic [7:0]  IfgLast   = 8'(IFG - 1);
  localparam logic [7:0]  StartLast = 8'(START_TO - 1);
  localparam logic [10:0] MaxLen    = 11'(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StGrant, StSend, StGap} state_e;

  state_e      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  grant_q, grant_d;
  logic [7:0]  cnt_q, cnt_d;          // timeout counter in GRANT, gap counter in GAP
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic        trunc_wait_q, trunc_wait_d;
  logic [15:0] frames_q, frames_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        busy_q, busy_d;
  logic        timeout_q, timeout_d;
  logic        trunc_q, trunc_d;

  logic [1:0]  rr_pick;
  logic [1:0]  rr_cand;
  logic [7:0]  sel_byte;
  logic        sel_valid;
  logic        sel_req;

  assign sel_byte  = ch_data[{sel_q, 3'b000} +: 8];
  assign sel_valid = ch_valid[sel_q];
  assign sel_req   = req[sel_q];

  // First requester after ptr_q, cyclic. Walking offsets from far to near lets the nearest
  // requester overwrite the others; offset 4 wraps to the last-served source itself.
  always_comb begin
    rr_pick = ptr_q;
    rr_cand = ptr_q;
    for (int off = 4; off >= 1; off--) begin
      rr_cand = ptr_q + 2'(off);
      if (req[rr_cand]) rr_pick = rr_cand;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    byte_cnt_d   = byte_cnt_q;
    trunc_wait_d = trunc_wait_q;
    frames_d     = frames_q;
    tx_data_d    = 8'h00;
    tx_valid_d   = 1'b0;
    timeout_d    = 1'b0;
    trunc_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          sel_d   = rr_pick;
          grant_d = 4'(4'b0001 << rr_pick);
          cnt_d   = 8'd0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (sel_valid) begin
          tx_data_d  = sel_byte;
          tx_valid_d = 1'b1;
          byte_cnt_d = 11'd1;
          state_d    = StSend;
        end else if (!sel_req || cnt_q == StartLast) begin
          grant_d   = 4'd0;
          timeout_d = 1'b1;
          ptr_d     = sel_q;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StSend: begin
        if (!sel_valid) begin
          grant_d      = 4'd0;
          frames_d     = frames_q + 16'd1;
          ptr_d        = sel_q;
          cnt_d        = 8'd0;
          trunc_wait_d = 1'b0;
          state_d      = StGap;
        end else if (byte_cnt_q == MaxLen) begin
          grant_d      = 4'd0;
          trunc_d      = 1'b1;
          ptr_d        = sel_q;
          cnt_d        = 8'd0;
          trunc_wait_d = 1'b1;
          state_d      = StGap;
        end else begin
          tx_data_d  = sel_byte;
          tx_valid_d = 1'b1;
          byte_cnt_d = byte_cnt_q + 11'd1;
        end
      end
      StGap: begin
        // After a truncation the gap only starts counting once the cut source drops valid,
        // so its leftover bytes can never be mistaken for a new frame.
        if (trunc_wait_q) begin
          cnt_d = 8'd0;
          if (!sel_valid) trunc_wait_d = 1'b0;
        end else if (cnt_q == IfgLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sel_q        <= 2'd0;
      ptr_q        <= 2'd3;
      grant_q      <= 4'd0;
      cnt_q        <= 8'd0;
      byte_cnt_q   <= 11'd0;
      trunc_wait_q <= 1'b0;
      frames_q     <= 16'd0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      trunc_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      trunc_wait_q <= trunc_wait_d;
      frames_q     <= frames_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      trunc_q      <= trunc_d;
    end
  end

  assign grant         = grant_q;
  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;
  assign busy          = busy_q;
  assign frames_sent   = frames_q;
  assign timeout_pulse = timeout_q;
  assign trunc_pulse   = trunc_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter. A second instance built with MAX_LEN=16 shares the
// stimulus and is only examined in the truncation step.
module tb_udp_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] ch_data;
  logic [3:0]  ch_valid;

  logic [3:0]  grant, grant_t;
  logic [7:0]  tx_data, tx_data_t;
  logic        tx_data_valid, tx_data_valid_t;
  logic        busy, busy_t;
  logic [15:0] frames_sent, frames_sent_t;
  logic        timeout_pulse, timeout_pulse_t;
  logic        trunc_pulse, trunc_pulse_t;

  int vectors;
  int miscompares;

  udp_tx_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .ch_data       (ch_data),
    .ch_valid      (ch_valid),
    .grant         (grant),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .busy          (busy),
    .frames_sent   (frames_sent),
    .timeout_pulse (timeout_pulse),
    .trunc_pulse   (trunc_pulse)
  );

  udp_tx_arbiter #(.MAX_LEN(16)) dut_t (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .ch_data       (ch_data),
    .ch_valid      (ch_valid),
    .grant         (grant_t),
    .tx_data       (tx_data_t),
    .tx_data_valid (tx_data_valid_t),
    .busy          (busy_t),
    .frames_sent   (frames_sent_t),
    .timeout_pulse (timeout_pulse_t),
    .trunc_pulse   (trunc_pulse_t)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = 4'd0;
    ch_valid = 4'd0;
    ch_data  = 32'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Ticks until the chosen instance shows a grant; returns the number of edges waited.
  task automatic wait_grant(input bit use_t, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (((use_t ? grant_t : grant) == 4'd0) && n < 200);
  endtask

  // Drives a frame on source src (already granted) and checks each forwarded byte, then
  // drops valid and checks the frame end. noise toggles source 3 alongside.
  task automatic send_frame(input int src, input int n, input logic [7:0] base, input bit inc,
                            input bit noise);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = inc ? 8'(base + 8'(i)) : base;
      ch_valid = 4'd0;
      ch_valid[src] = 1'b1;
      ch_data = 32'd0;
      ch_data[8*src +: 8] = b;
      if (noise) begin
        ch_valid[3]    = i[0];
        ch_data[31:24] = 8'hEE;
      end
      tick();
      chk("byte_valid", 32'(tx_data_valid), 1);
      chk("byte_data", 32'(tx_data), 32'(b));
      chk("byte_grant", 32'(grant), 32'(1 << src));
    end
    ch_valid = 4'd0;
    ch_data  = 32'd0;
    tick();
    chk("end_valid", 32'(tx_data_valid), 0);
    chk("end_grant", 32'(grant), 0);
    chk("end_busy", 32'(busy), 1);
  endtask

  initial begin
    int n;
    int pulses;
    vectors     = 0;
    miscompares = 0;

    // Reset values
    do_reset();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_valid", 32'(tx_data_valid), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frames", 32'(frames_sent), 0);
    chk("rst_pulses", 32'({timeout_pulse, trunc_pulse}), 0);

    // Source 0 alone: 60-byte counting frame, then gap and back-to-back re-grant
    req = 4'b0001;
    tick();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_nobyte", 32'(tx_data_valid), 0);
    send_frame(0, 60, 8'h00, 1'b1, 1'b0);
    chk("t1_frames", 32'(frames_sent), 1);
    wait_grant(1'b0, n);
    chk("t1_gap", 32'(n), 13);
    chk("t1_regrant", 32'(grant), 32'h1);

    // Source 3 toggles valid during source 0's frame; only source 0 bytes go out
    send_frame(0, 8, 8'h50, 1'b1, 1'b1);
    chk("t5_frames", 32'(frames_sent), 2);

    // All four request: grant order 0,1,2,3,0 with full gaps
    do_reset();
    req = 4'b1111;
    tick();
    chk("t2_first", 32'(grant), 32'h1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        wait_grant(1'b0, n);
        chk("t2_gap", 32'(n), 13);
        chk("t2_order", 32'(grant), 32'(1 << (k % 4)));
      end
      if (k == 4) req = 4'b1100;
      send_frame(k % 4, 10, 8'(8'hA0 + 8'(k % 4)), 1'b0, 1'b0);
    end
    chk("t2_frames", 32'(frames_sent), 5);

    // Source 2 granted but silent: withdrawn after 64 cycles, then source 3 served
    wait_grant(1'b0, n);
    chk("t3_gap", 32'(n), 13);
    chk("t3_grant2", 32'(grant), 32'h4);
    n = 0;
    pulses = 0;
    do begin
      tick();
      n++;
      if (timeout_pulse) pulses++;
    end while (grant != 4'd0 && n < 200);
    chk("t3_to_cycles", 32'(n), 64);
    chk("t3_to_pulse", 32'(timeout_pulse), 1);
    chk("t3_to_pulses", 32'(pulses), 1);
    tick();
    chk("t3_pulse_off", 32'(timeout_pulse), 0);
    chk("t3_grant3", 32'(grant), 32'h8);
    req = 4'b0000;
    tick();
    chk("t3_wd_grant", 32'(grant), 0);
    chk("t3_wd_pulse", 32'(timeout_pulse), 1);
    chk("t3_wd_busy", 32'(busy), 0);
    chk("t3_frames", 32'(frames_sent), 5);

    // Reset in the middle of a 40-byte frame
    req = 4'b0001;
    tick();
    chk("t6_grant", 32'(grant), 32'h1);
    for (int i = 0; i < 5; i++) begin
      ch_valid = 4'b0001;
      ch_data  = 32'(8'h80 + 8'(i));
      tick();
      chk("t6_byte", 32'(tx_data), 32'(8'h80 + i));
    end
    ch_data = 32'h85;
    rst     = 1'b1;
    tick();
    chk("t6_valid", 32'(tx_data_valid), 0);
    chk("t6_grant0", 32'(grant), 0);
    chk("t6_frames", 32'(frames_sent), 0);
    chk("t6_busy", 32'(busy), 0);
    rst      = 1'b0;
    ch_valid = 4'd0;
    ch_data  = 32'd0;
    req      = 4'b1111;
    tick();
    chk("t6_first", 32'(grant), 32'h1);

    // MAX_LEN=16 instance: 20-byte frame from source 1 cut after 16 bytes
    do_reset();
    req = 4'b0010;
    tick();
    chk("t4_grant", 32'(grant_t), 32'h2);
    for (int i = 0; i < 20; i++) begin
      ch_valid = 4'b0010;
      ch_data  = {16'd0, 8'(8'h30 + 8'(i)), 8'd0};
      tick();
      if (i < 16) begin
        chk("t4_valid", 32'(tx_data_valid_t), 1);
        chk("t4_data", 32'(tx_data_t), 32'(8'h30 + i));
      end else if (i == 16) begin
        chk("t4_cut_valid", 32'(tx_data_valid_t), 0);
        chk("t4_cut_pulse", 32'(trunc_pulse_t), 1);
        chk("t4_cut_grant", 32'(grant_t), 0);
      end else begin
        chk("t4_tail_valid", 32'(tx_data_valid_t), 0);
        chk("t4_tail_pulse", 32'(trunc_pulse_t), 0);
      end
    end
    ch_valid = 4'd0;
    ch_data  = 32'd0;
    tick();
    chk("t4_end_grant", 32'(grant_t), 0);
    chk("t4_frames", 32'(frames_sent_t), 0);
    wait_grant(1'b1, n);
    chk("t4_gap", 32'(n), 13);
    chk("t4_regrant", 32'(grant_t), 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
